wb_commit_unit: RTL
===================

// Module: wb_commit_unit
// PURPOSE
//  Parametrised writeback/commit stage. Consumes the MEM latch and drives the register-file write
//  port (to DE) and a matching forwarding bus (to AGEX). Owns the memory-mapped HEX and LEDR
//  output registers; LEDR has set/clear alias addresses. Keeps a saturating retire counter and a
//  RUN/HALTED state machine, so a halt instruction freezes all architectural state.
// PARAMETERS
//  DBITS       32            data/address width
//  REGNOBITS   4             register-number width; register 0 is never written
//  HEX_DIGITS  6             number of 4-bit HEX digits held (1..8)
//  HEX_RESET   24'hFEDEAD    HEX register reset value, width 4*HEX_DIGITS
//  LEDR_BITS   10            LEDR register width (1..DBITS)
//  ADDR_HEX    32'hFFFFF000  HEX store address
//  ADDR_LEDR   32'hFFFFF020  LEDR store address; set alias at +4, clear alias at +8
//  CNT_BITS    32            retire-counter width
// PORTS
//  clk          in   1                  clock, all state on rising edge
//  reset_n      in   1                  asynchronous, active-low reset
//  in_valid     in   1                  MEM latch holds a real instruction this cycle
//  in_pc        in   DBITS              PC of that instruction
//  in_memaddr   in   DBITS              store address
//  in_regval    in   DBITS              register writeback data
//  in_regval2   in   DBITS              store data
//  in_wr_mem    in   1                  instruction is a store
//  in_wr_reg    in   1                  instruction writes a register
//  in_wregno    in   REGNOBITS          destination register
//  in_halt      in   1                  instruction is a halt
//  rf_we        out  1                  register-file write enable (to DE)
//  rf_wregno    out  REGNOBITS          register-file write index
//  rf_wdata     out  DBITS              register-file write data
//  fwd_valid    out  1                  forwarding bus valid (to AGEX); equals rf_we
//  fwd_regno    out  REGNOBITS          forwarded register
//  fwd_data     out  DBITS              forwarded data
//  hex_out      out  4*HEX_DIGITS       HEX digit register
//  ledr_out     out  LEDR_BITS          LEDR register
//  retire_cnt   out  CNT_BITS           committed-instruction count
//  halted       out  1                  1 while in HALTED
//  halt_pc      out  DBITS              PC of the halting instruction
// BEHAVIOUR
//  Handshake: none. The stage accepts every cycle and never stalls upstream.
//  commit = in_valid & (state==RUN).
//  Register write (combinational, same cycle):
//   - rf_we = commit & in_wr_reg & (in_wregno!=0).
//   - rf_wregno = in_wregno and rf_wdata = in_regval, always passed through.
//   - fwd_* mirror rf_*.
//  Stores (registered, visible the cycle after commit), all when commit & in_wr_mem:
//   - addr==ADDR_HEX:    hex_out  <= in_regval2[4*HEX_DIGITS-1:0]
//   - addr==ADDR_LEDR:   ledr_out <= in_regval2[LEDR_BITS-1:0]
//   - addr==ADDR_LEDR+4: ledr_out <= ledr_out |  in_regval2[LEDR_BITS-1:0]
//   - addr==ADDR_LEDR+8: ledr_out <= ledr_out & ~in_regval2[LEDR_BITS-1:0]
//   - Any other address leaves both registers unchanged. Compares are full DBITS width.
//  Retire counter: +1 on every commit; saturates at all-ones (no wrap).
//  FSM, two states:
//   - RUN -> HALTED when commit & in_halt. The halting instruction fully commits:
//     counted, reg write and store both performed. halt_pc <= in_pc.
//   - HALTED is sticky and left only by reset. While HALTED, commit=0: no rf_we, no stores,
//     counter frozen. halted=1 from the cycle after the halt commits.
//  Reset (reset_n low, asynchronous, including mid-operation):
//   - state=RUN, hex_out=HEX_RESET, ledr_out=0, retire_cnt=0, halt_pc=0, halted=0.
//   - rf_we/fwd_valid are 0 while reset_n is low.
//  Non-architectural (simulation aid): array last_wb_value[2**REGNOBITS] (verilator public),
//  written with in_regval at in_wregno whenever rf_we is 1.
// TESTING
//  1 Reset: hold reset_n=0 -> hex_out=24'hFEDEAD, ledr_out=0, retire_cnt=0, halted=0.
//  2 Reg write: commit wr_reg, wregno=5, regval=32'h1234 -> same cycle rf_we=1, fwd_data=32'h1234.
//    Same with wregno=0 -> rf_we=0.
//  3 LEDR aliases: store 10'h0F0 to ADDR_LEDR, then 10'h003 to +4, then 10'h010 to +8
//    -> ledr_out = 10'h0F0, 10'h0F3, 10'h0E3. Store to ADDR_LEDR+12 -> unchanged.
//  4 HEX: store 32'hABCDEF12 to ADDR_HEX -> hex_out=24'hCDEF12 next cycle. in_valid=0 -> no update.
//  5 Halt: 3 commits, then a halt at pc=32'h40 that also writes reg 2, then 2 more valid
//    -> retire_cnt=4, halted=1, halt_pc=32'h40, reg-2 write seen, later rf_we=0.
//  6 Saturation/reset: CNT_BITS=4, 17 commits -> retire_cnt=4'hF. Assert reset_n mid-stream
//    -> all outputs return to reset values immediately (asynchronously).

Source files
------------

// File: rtl/wb_commit_if.sv
// MEM-latch to writeback bus: instruction fields in, register-file write port and forwarding bus out.
// slave is the commit stage, master is whatever drives the MEM latch and samples rf/fwd.
interface wb_commit_if #(
  parameter int DBITS     = 32,
  parameter int REGNOBITS = 4
);
  logic                 in_valid;
  logic [DBITS-1:0]     in_pc;
  logic [DBITS-1:0]     in_memaddr;
  logic [DBITS-1:0]     in_regval;
  logic [DBITS-1:0]     in_regval2;
  logic                 in_wr_mem;
  logic                 in_wr_reg;
  logic [REGNOBITS-1:0] in_wregno;
  logic                 in_halt;

  logic                 rf_we;
  logic [REGNOBITS-1:0] rf_wregno;
  logic [DBITS-1:0]     rf_wdata;
  logic                 fwd_valid;
  logic [REGNOBITS-1:0] fwd_regno;
  logic [DBITS-1:0]     fwd_data;

  modport slave (
    input  in_valid, in_pc, in_memaddr, in_regval, in_regval2,
           in_wr_mem, in_wr_reg, in_wregno, in_halt,
    output rf_we, rf_wregno, rf_wdata, fwd_valid, fwd_regno, fwd_data
  );

  modport master (
    output in_valid, in_pc, in_memaddr, in_regval, in_regval2,
           in_wr_mem, in_wr_reg, in_wregno, in_halt,
    input  rf_we, rf_wregno, rf_wdata, fwd_valid, fwd_regno, fwd_data
  );
endinterface

// File: rtl/wb_commit_unit.sv
// Writeback/commit stage: register-file write and forwarding, memory-mapped HEX/LEDR
// output registers, saturating retire counter and a sticky RUN/HALTED state machine.
module wb_commit_unit #(
  parameter int                     DBITS      = 32,
  parameter int                     REGNOBITS  = 4,
  parameter int                     HEX_DIGITS = 6,
  parameter logic [4*HEX_DIGITS-1:0] HEX_RESET = 24'hFEDEAD,
  parameter int                     LEDR_BITS  = 10,
  parameter logic [DBITS-1:0]       ADDR_HEX   = 32'hFFFFF000,
  parameter logic [DBITS-1:0]       ADDR_LEDR  = 32'hFFFFF020,
  parameter int                     CNT_BITS   = 32
) (
  input  logic                      clk,
  input  logic                      reset_n,
  wb_commit_if.slave                wb,
  output logic [4*HEX_DIGITS-1:0]   hex_out,
  output logic [LEDR_BITS-1:0]      ledr_out,
  output logic [CNT_BITS-1:0]       retire_cnt,
  output logic                      halted,
  output logic [DBITS-1:0]          halt_pc
);

  localparam logic [DBITS-1:0] ADDR_LEDR_SET = ADDR_LEDR + DBITS'(4);
  localparam logic [DBITS-1:0] ADDR_LEDR_CLR = ADDR_LEDR + DBITS'(8);

  typedef enum logic {RUN, HALTED} state_t;

  state_t                state_q, state_d;
  logic                  commit;
  logic                  rf_we_c;
  logic [LEDR_BITS-1:0]  store_ledr;
  logic [DBITS-1:0]      last_wb_value [2**REGNOBITS];
  logic                  unused_sink;

  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] c);
    return (c == '1) ? c : c + CNT_BITS'(1);
  endfunction

  // Reset is folded into commit so nothing writes while reset_n is held low.
  always_comb begin
    commit  = 1'b0;
    state_d = state_q;
    if (reset_n && wb.in_valid && state_q == RUN) begin
      commit = 1'b1;
      if (wb.in_halt) state_d = HALTED;
    end
  end

  assign rf_we_c      = commit & wb.in_wr_reg & (wb.in_wregno != '0);
  assign wb.rf_we     = rf_we_c;
  assign wb.rf_wregno = wb.in_wregno;
  assign wb.rf_wdata  = wb.in_regval;
  assign wb.fwd_valid = rf_we_c;
  assign wb.fwd_regno = wb.in_wregno;
  assign wb.fwd_data  = wb.in_regval;

  assign store_ledr = wb.in_regval2[LEDR_BITS-1:0];
  assign halted     = (state_q == HALTED);

  // Architectural state: everything updates only on a committing instruction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RUN;
      hex_out    <= HEX_RESET;
      ledr_out   <= '0;
      retire_cnt <= '0;
      halt_pc    <= '0;
    end else begin
      state_q <= state_d;
      if (commit) begin
        retire_cnt <= sat_inc(retire_cnt);
        if (wb.in_halt) halt_pc <= wb.in_pc;
        if (wb.in_wr_mem) begin
          if (wb.in_memaddr == ADDR_HEX)
            hex_out <= wb.in_regval2[4*HEX_DIGITS-1:0];
          else if (wb.in_memaddr == ADDR_LEDR)
            ledr_out <= store_ledr;
          else if (wb.in_memaddr == ADDR_LEDR_SET)
            ledr_out <= ledr_out | store_ledr;
          else if (wb.in_memaddr == ADDR_LEDR_CLR)
            ledr_out <= ledr_out & ~store_ledr;
        end
      end
    end
  end

  // Debug shadow of the register file, visible to simulation only.
  always_ff @(posedge clk) begin
    if (rf_we_c) last_wb_value[wb.in_wregno] <= wb.in_regval;
  end

  assign unused_sink = ^{wb.in_regval2, last_wb_value[wb.in_wregno]};

endmodule
